// File: rtl/ps2_kbd_tx_if.sv
// Write-side bus of the PS/2 keyboard transmitter: scancode bytes in,
// FIFO status out.
interface ps2_kbd_tx_if;
  logic [7:0] din;
  logic       wr;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (output din, wr, input full, overflow, busy);
  modport slave  (input din, wr, output full, overflow, busy);
endinterface

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scancode bytes in a FIFO and
// sends each one as an 11-bit frame, one half-bit per tick strobe.
module ps2_kbd_tx #(
  parameter int FIFO_AW   = 4,
  parameter int GAP_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  ps2_kbd_tx_if.slave bus,
  output logic        ps2_kbd_clk,
  output logic        ps2_kbd_data
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0]         GAP_LOAD = 8'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_STOPH,
    S_GAP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, overflow_q, busy_q;
  logic               empty, push, pop;
  logic [7:0]         rd_byte;

  state_t             state_q, state_d;
  logic [10:0]        shift_q, shift_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         gapcnt_q, gapcnt_d;
  logic               kclk_d, kdata_d;

  assign empty   = (count_q == '0);
  assign rd_byte = mem[rd_ptr];
  // A write into a full FIFO still lands when the same clk pops a byte out.
  assign push    = bus.wr && (!full_q || pop);

  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    kclk_d   = ps2_kbd_clk;
    kdata_d  = ps2_kbd_data;
    pop      = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE, S_GAP: begin
          if (state_q == S_GAP && gapcnt_q != '0) begin
            gapcnt_d = gapcnt_q - 8'd1;
          end else if (!empty) begin
            pop      = 1'b1;
            shift_d  = {1'b1, ~^rd_byte, rd_byte, 1'b0};
            kclk_d   = 1'b1;
            kdata_d  = shift_d[0];
            bitcnt_d = 4'd0;
            state_d  = S_LOW;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_LOW: begin
          kclk_d  = 1'b0;
          state_d = (bitcnt_q == 4'd10) ? S_STOPH : S_HIGH;
        end
        S_HIGH: begin
          // Data only moves while the clock line is high.
          kclk_d   = 1'b1;
          shift_d  = {1'b1, shift_q[10:1]};
          kdata_d  = shift_q[1];
          bitcnt_d = bitcnt_q + 4'd1;
          state_d  = S_LOW;
        end
        S_STOPH: begin
          kclk_d   = 1'b1;
          kdata_d  = 1'b1;
          gapcnt_d = GAP_LOAD;
          state_d  = S_GAP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '1;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      ps2_kbd_clk  <= 1'b1;
      ps2_kbd_data <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      gapcnt_q     <= gapcnt_d;
      ps2_kbd_clk  <= kclk_d;
      ps2_kbd_data <= kdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == FULL_CNT);
      overflow_q <= bus.wr && !push;
      busy_q     <= (state_d != S_IDLE) || (count_d != '0);
    end
  end

  // NOTE: storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: decodes frames off the PS/2 lines and
// compares them with hand-computed frames and FIFO status values.
module tb_ps2_kbd_tx;

  localparam int GAP = 8;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic tick_auto = 1'b0;
  logic tick_man  = 1'b0;
  logic tick_en   = 1'b0;
  logic tick;
  logic ps2_kbd_clk, ps2_kbd_data;

  assign tick = tick_auto | tick_man;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(.FIFO_AW(4), .GAP_TICKS(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .bus          (bus),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame built by counting ones rather than by reduction XOR.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Tick strobe: one clk wide, every 4th clk while enabled.
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      tick_auto = tick_en && (div == 0);
    end
  end

  // Line monitor: collects data at each clk fall, measures idle runs between frames.
  logic [10:0] rx_q[$];
  int          gap_q[$];
  logic        tick_seen  = 1'b0;
  logic        prev_clk   = 1'b1;
  logic [10:0] bits       = '0;
  int          nbits      = 0;
  int          n_falls    = 0;
  int          hi_run     = 0;
  int          since_fall = 0;

  initial forever begin
    @(posedge clk);
    tick_seen <= tick;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      nbits    = 0;
      hi_run   = 0;
      prev_clk = 1'b1;
    end else begin
      logic fall;
      fall = prev_clk && !ps2_kbd_clk;
      if (fall) begin
        bits[nbits] = ps2_kbd_data;
        nbits++;
        n_falls++;
        if (nbits == 11) begin
          rx_q.push_back(bits);
          nbits = 0;
        end
      end
      if (tick_seen) begin
        since_fall = fall ? 0 : since_fall + 1;
        if (ps2_kbd_clk && ps2_kbd_data) begin
          hi_run++;
        end else begin
          if (ps2_kbd_clk && !ps2_kbd_data && nbits == 0) gap_q.push_back(hi_run);
          hi_run = 0;
        end
      end
      prev_clk = ps2_kbd_clk;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    bus.din = b;
    bus.wr  = 1'b1;
    @(negedge clk);
    bus.wr  = 1'b0;
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (rx_q.size() < n) check("frame_timeout", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (bus.busy && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (bus.busy) check("idle_timeout", bus.busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int falls0;
    logic [10:0] f;
    bus.din = '0;
    bus.wr  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_clk",      ps2_kbd_clk,  1'b1);
    check("rst_data",     ps2_kbd_data, 1'b1);
    check("rst_full",     bus.full,     1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_busy",     bus.busy,     1'b0);
    @(negedge clk);
    reset   = 1'b0;
    tick_en = 1'b1;
    repeat (8) @(negedge clk);

    // 1: 0x1C, parity 0
    falls0 = n_falls;
    write_byte(8'h1C);
    check("t1_busy", bus.busy, 1'b1);
    wait_frames(1, 400);
    check("t1_falls", n_falls - falls0, 11);
    check("t1_frame", rx_q.pop_front(), 11'h438);
    wait_idle(200);
    check("t1_busy_drop_ticks", since_fall, GAP + 1);

    // 2: 0x00, parity 1
    write_byte(8'h00);
    wait_frames(1, 400);
    check("t2_frame", rx_q.pop_front(), 11'h600);
    wait_idle(200);

    // 3: back-to-back bytes, gap between frames
    gap_q.delete();
    @(negedge clk);
    bus.din = 8'hF0;
    bus.wr  = 1'b1;
    @(negedge clk);
    bus.din = 8'h1C;
    @(negedge clk);
    bus.wr  = 1'b0;
    wait_frames(2, 800);
    check("t3_frame0", rx_q.pop_front(), 11'h7E0);
    check("t3_frame1", rx_q.pop_front(), 11'h438);
    check("t3_gap", gap_q[1], GAP);
    wait_idle(200);

    // 4: fill with no tick, overflow on 17th, then drain
    @(negedge clk);
    #1;
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      write_byte(8'(i));
      if (i == 15) check("t4_not_full_15", bus.full, 1'b0);
    end
    check("t4_full_16", bus.full, 1'b1);
    check("t4_idle_lines", {ps2_kbd_clk, ps2_kbd_data}, 2'b11);
    check("t4_busy_queued", bus.busy, 1'b1);
    write_byte(8'h11);
    check("t4_overflow", bus.overflow, 1'b1);
    @(negedge clk);
    #1;
    check("t4_overflow_pulse", bus.overflow, 1'b0);
    check("t4_still_full", bus.full, 1'b1);
    tick_en = 1'b1;
    wait_frames(16, 4000);
    for (int i = 1; i <= 16; i++) begin
      f = rx_q.pop_front();
      check($sformatf("t4_frame%0d", i), f, frame_of(8'(i)));
    end
    wait_idle(200);
    check("t4_no_extra", rx_q.size(), 0);

    // 5: reset during bit 5 with 3 bytes queued
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    begin
      int cyc = 0;
      while (nbits != 5 && cyc < 400) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("t5_reach_bit5", nbits, 5);
    end
    reset = 1'b1;
    #1;
    check("t5_rst_lines", {ps2_kbd_clk, ps2_kbd_data}, 2'b11);
    check("t5_rst_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    falls0 = n_falls;
    repeat (400) @(negedge clk);
    #1;
    check("t5_no_falls", n_falls - falls0, 0);
    check("t5_no_frames", rx_q.size(), 0);
    check("t5_idle_busy", bus.busy, 1'b0);

    // 6: full FIFO, write coincident with the popping tick
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) write_byte(8'h21 + 8'(i));
    check("t6_full", bus.full, 1'b1);
    @(negedge clk);
    tick_man = 1'b1;
    bus.din  = 8'h31;
    bus.wr   = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
    bus.wr   = 1'b0;
    #1;
    check("t6_no_overflow", bus.overflow, 1'b0);
    check("t6_full_kept", bus.full, 1'b1);
    check("t6_start_bit", {ps2_kbd_clk, ps2_kbd_data}, 2'b10);
    tick_en = 1'b1;
    wait_frames(17, 5000);
    for (int i = 0; i < 17; i++) begin
      f = rx_q.pop_front();
      check($sformatf("t6_frame%0d", i), f, frame_of(8'h21 + 8'(i)));
    end
    wait_idle(200);
    check("t6_drained", bus.full, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
